my_serdes_rx: RTL and testbench

Receive end of the 16-bit SERDES link fed by my_serdes_tx. It acquires word-pair alignment from the COMMA/COMMA/SYNC/SYNC resync burst and then validates the control-word framing. Data words pass into a small FIFO behind a guarded dequeue interface for the DSP side. It also reports lock, overflow and link errors.

---
 rtl/my_serdes_rx_if.sv | 20 ++
 rtl/my_serdes_rx.sv | 206 ++++++++++++++++++++
 tb/tb_my_serdes_rx.sv | 353 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/my_serdes_rx_if.sv
// Receive-side bundle: the incoming SERDES word with its K flags, plus the
// guarded dequeue port that the DSP side uses to drain the data FIFO.
interface my_serdes_rx_if;
    logic [15:0] ser_r;
    logic        ser_rklsb;
    logic        ser_rkmsb;
    logic [15:0] rx_dat_o;
    logic        rx_rdy;
    logic        rx_en;

    modport master (
        output ser_r, ser_rklsb, ser_rkmsb, rx_en,
        input  rx_dat_o, rx_rdy
    );

    modport slave (
        input  ser_r, ser_rklsb, ser_rkmsb, rx_en,
        output rx_dat_o, rx_rdy
    );
endinterface

// File: rtl/my_serdes_rx.sv
// SERDES receiver: hunts for the COMMA/COMMA/SYNC/SYNC burst, checks the framing
// while locked and queues data words into a small FIFO for the DSP side.
module my_serdes_rx #(
    parameter int FIFOSIZE      = 4,
    parameter int CNTR_WIDTH    = 2,
    parameter int LOCK_TIMEOUT  = 0,
    parameter int TIMEOUT_WIDTH = 20
) (
    input  logic               dsp_clk,
    input  logic               dsp_rst_n,
    my_serdes_rx_if.slave      rx,
    input  logic               err_clr,
    output logic               locked,
    output logic               overflow,
    output logic [7:0]         err_cnt,
    output logic [7:0]         debug
);

    localparam logic [15:0] W_IDLE  = 16'h1C1C;
    localparam logic [15:0] W_COMMA = 16'h3C3C;
    localparam logic [15:0] W_SYNC  = 16'h9C9C;

    typedef enum logic [2:0] {
        HUNT, H_C1, H_C2, H_S1, LOCKED, L_C1, L_C2, L_S1
    } state_t;

    typedef enum logic [2:0] {
        CL_DATA, CL_IDLE, CL_COMMA, CL_SYNC, CL_BAD
    } class_t;

    logic [15:0]              r_ser;
    logic                     r_klsb, r_kmsb;
    class_t                   cls;
    state_t                   state, state_nx;
    logic                     parity;
    logic [TIMEOUT_WIDTH-1:0] tmo_cnt;
    logic                     tmo_expire;
    logic                     enq, err_evt, par_tgl, par_clr, tmo_load;

    logic [15:0]              mem [FIFOSIZE];
    logic [CNTR_WIDTH-1:0]    wr_ptr, rd_ptr;
    logic [CNTR_WIDTH:0]      count;
    logic                     full, not_empty, push, pop, ovf_evt;

    function automatic logic [CNTR_WIDTH-1:0] ptr_inc(input logic [CNTR_WIDTH-1:0] p);
        return (p == CNTR_WIDTH'(FIFOSIZE - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
        if (!dsp_rst_n) begin
            r_ser  <= W_IDLE;
            r_klsb <= 1'b1;
            r_kmsb <= 1'b1;
        end else begin
            r_ser  <= rx.ser_r;
            r_klsb <= rx.ser_rklsb;
            r_kmsb <= rx.ser_rkmsb;
        end
    end

    // Mixed K flags and unknown control bytes all fall through to BAD.
    always_comb begin
        cls = CL_BAD;
        if (!r_kmsb && !r_klsb) begin
            cls = CL_DATA;
        end else if (r_kmsb && r_klsb) begin
            case (r_ser)
                W_IDLE:  cls = CL_IDLE;
                W_COMMA: cls = CL_COMMA;
                W_SYNC:  cls = CL_SYNC;
                default: cls = CL_BAD;
            endcase
        end
    end

    assign tmo_expire = (LOCK_TIMEOUT > 0) && (tmo_cnt == TIMEOUT_WIDTH'(1));

    always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
        if (!dsp_rst_n) state <= HUNT;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        enq      = 1'b0;
        err_evt  = 1'b0;
        par_tgl  = 1'b0;
        par_clr  = 1'b0;
        tmo_load = 1'b0;
        case (state)
            HUNT: if (cls == CL_COMMA) state_nx = H_C1;
            H_C1: state_nx = (cls == CL_COMMA) ? H_C2 : HUNT;
            H_C2: begin
                if (cls == CL_SYNC)       state_nx = H_S1;
                else if (cls == CL_COMMA) state_nx = H_C1;
                else                      state_nx = HUNT;
            end
            H_S1: begin
                if (cls == CL_SYNC) begin
                    state_nx = LOCKED;
                    par_clr  = 1'b1;
                    tmo_load = 1'b1;
                end else begin
                    state_nx = HUNT;
                end
            end
            LOCKED: begin
                // Timeout wins over the word in flight and is not a link error.
                if (tmo_expire) begin
                    state_nx = HUNT;
                end else begin
                    case (cls)
                        CL_DATA: begin
                            enq     = 1'b1;
                            par_tgl = 1'b1;
                        end
                        CL_IDLE: ;
                        CL_COMMA: begin
                            if (!parity) begin
                                state_nx = L_C1;
                            end else begin
                                state_nx = HUNT;
                                err_evt  = 1'b1;
                            end
                        end
                        default: begin
                            state_nx = HUNT;
                            err_evt  = 1'b1;
                        end
                    endcase
                end
            end
            L_C1: begin
                if (cls == CL_COMMA) state_nx = L_C2;
                else begin state_nx = HUNT; err_evt = 1'b1; end
            end
            L_C2: begin
                if (cls == CL_SYNC) state_nx = L_S1;
                else begin state_nx = HUNT; err_evt = 1'b1; end
            end
            L_S1: begin
                if (cls == CL_SYNC) begin
                    state_nx = LOCKED;
                    par_clr  = 1'b1;
                    tmo_load = 1'b1;
                end else begin
                    state_nx = HUNT;
                    err_evt  = 1'b1;
                end
            end
            default: state_nx = HUNT;
        endcase
    end

    assign locked    = state[2];
    assign full      = (count == (CNTR_WIDTH + 1)'(FIFOSIZE));
    assign not_empty = (count != '0);
    assign push      = enq && !full;
    assign ovf_evt   = enq && full;
    assign pop       = rx.rx_en && not_empty;

    always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
        if (!dsp_rst_n) begin
            parity   <= 1'b0;
            tmo_cnt  <= '0;
            err_cnt  <= 8'd0;
            overflow <= 1'b0;
        end else begin
            if (par_clr)      parity <= 1'b0;
            else if (par_tgl) parity <= ~parity;

            if (tmo_load && (LOCK_TIMEOUT > 0)) tmo_cnt <= TIMEOUT_WIDTH'(LOCK_TIMEOUT);
            else if (state[2] && tmo_cnt != '0) tmo_cnt <= tmo_cnt - 1'b1;

            if (err_clr)                          err_cnt <= err_evt ? 8'd1 : 8'd0;
            else if (err_evt && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;

            overflow <= err_clr ? ovf_evt : (overflow | ovf_evt);
        end
    end

    always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
        if (!dsp_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge dsp_clk) begin
        if (push) mem[wr_ptr] <= r_ser;
    end

    assign rx.rx_dat_o = mem[rd_ptr];
    assign rx.rx_rdy   = not_empty;
    assign debug       = {locked, overflow, parity, not_empty, cls[1:0], state[1:0]};

endmodule

// File: tb/tb_my_serdes_rx.sv
// Bench for my_serdes_rx: one instance with the timeout disabled, one with a
// 100-cycle lock timeout, both fed the same receive stream.
module tb_my_serdes_rx;

    localparam logic [15:0] W_IDLE  = 16'h1C1C;
    localparam logic [15:0] W_COMMA = 16'h3C3C;
    localparam logic [15:0] W_SYNC  = 16'h9C9C;
    localparam logic [1:0]  K_CTRL  = 2'b11;
    localparam logic [1:0]  K_DATA  = 2'b00;

    logic        dsp_clk = 1'b0;
    logic        dsp_rst_n = 1'b0;
    logic [15:0] ser_r = W_IDLE;
    logic        ser_rklsb = 1'b1;
    logic        ser_rkmsb = 1'b1;
    logic        rx_en = 1'b0;
    logic        err_clr = 1'b0;

    logic        locked0, overflow0, locked1, overflow1;
    logic [7:0]  err_cnt0, debug0, err_cnt1, debug1;

    int          vectors = 0;
    int          miscompares = 0;
    logic [15:0] exp_q[$];

    always #5 dsp_clk = ~dsp_clk;

    my_serdes_rx_if rx_if0();
    my_serdes_rx_if rx_if1();

    assign rx_if0.ser_r     = ser_r;
    assign rx_if0.ser_rklsb = ser_rklsb;
    assign rx_if0.ser_rkmsb = ser_rkmsb;
    assign rx_if0.rx_en     = rx_en;
    assign rx_if1.ser_r     = ser_r;
    assign rx_if1.ser_rklsb = ser_rklsb;
    assign rx_if1.ser_rkmsb = ser_rkmsb;
    assign rx_if1.rx_en     = rx_en;

    my_serdes_rx dut0 (
        .dsp_clk(dsp_clk), .dsp_rst_n(dsp_rst_n), .rx(rx_if0), .err_clr(err_clr),
        .locked(locked0), .overflow(overflow0), .err_cnt(err_cnt0), .debug(debug0)
    );

    my_serdes_rx #(.LOCK_TIMEOUT(100)) dut1 (
        .dsp_clk(dsp_clk), .dsp_rst_n(dsp_rst_n), .rx(rx_if1), .err_clr(err_clr),
        .locked(locked1), .overflow(overflow1), .err_cnt(err_cnt1), .debug(debug1)
    );

    // Inputs change 1 time unit after the rising edge; returns just after the
    // edge that captured the word, which is also where outputs are sampled.
    task automatic drive(input logic [15:0] w, input logic [1:0] k);
        ser_r     = w;
        ser_rkmsb = k[1];
        ser_rklsb = k[0];
        @(posedge dsp_clk);
        #1;
    endtask

    task automatic burst();
        drive(W_COMMA, K_CTRL);
        drive(W_COMMA, K_CTRL);
        drive(W_SYNC, K_CTRL);
        drive(W_SYNC, K_CTRL);
    endtask

    task automatic do_lock();
        burst();
        drive(W_IDLE, K_CTRL);
    endtask

    task automatic do_reset();
        dsp_rst_n = 1'b0;
        err_clr   = 1'b0;
        rx_en     = 1'b0;
        ser_r     = W_IDLE;
        ser_rkmsb = 1'b1;
        ser_rklsb = 1'b1;
        repeat (2) @(posedge dsp_clk);
        #1;
        dsp_rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drain();
        logic [15:0] exp;
        int waited;
        ser_r     = W_IDLE;
        ser_rkmsb = 1'b1;
        ser_rklsb = 1'b1;
        while (exp_q.size() > 0) begin
            waited = 0;
            while (!rx_if0.rx_rdy && waited < 10) begin
                @(posedge dsp_clk);
                #1;
                waited++;
            end
            exp = exp_q.pop_front();
            vectors++;
            if (rx_if0.rx_rdy !== 1'b1 || rx_if0.rx_dat_o !== exp) begin
                miscompares++;
                $display("FAIL drain_data: rdy=%b got=%h expected=%h", rx_if0.rx_rdy, rx_if0.rx_dat_o, exp);
            end
            rx_en = 1'b1;
            @(posedge dsp_clk);
            #1;
            rx_en = 1'b0;
        end
        vectors++;
        if (rx_if0.rx_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL drain_empty: rx_rdy=%b expected=0", rx_if0.rx_rdy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (locked0 !== 1'b0 || overflow0 !== 1'b0 || err_cnt0 !== 8'd0 || rx_if0.rx_rdy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: locked=%b ovf=%b err=%0d rdy=%b expected 0/0/0/0",
                     locked0, overflow0, err_cnt0, rx_if0.rx_rdy);
        end
        vectors++;
        if (debug0 !== 8'h04) begin
            miscompares++;
            $display("FAIL reset_debug: got=%h expected=04", debug0);
        end
    endtask

    task automatic test_lock_data();
        do_reset();
        repeat (10) drive(W_IDLE, K_CTRL);
        burst();
        vectors++;
        if (locked0 !== 1'b0) begin
            miscompares++;
            $display("FAIL lock_early: locked=%b expected=0", locked0);
        end
        drive(16'h1234, K_DATA);
        exp_q.push_back(16'h1234);
        vectors++;
        if (locked0 !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_rise: locked=%b expected=1", locked0);
        end
        drive(16'h5678, K_DATA);
        exp_q.push_back(16'h5678);
        vectors++;
        if (rx_if0.rx_rdy !== 1'b1 || rx_if0.rx_dat_o !== 16'h1234) begin
            miscompares++;
            $display("FAIL data_latency: rdy=%b dat=%h expected 1/1234", rx_if0.rx_rdy, rx_if0.rx_dat_o);
        end
        drain();
        vectors++;
        if (err_cnt0 !== 8'd0 || locked0 !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_data_tail: err=%0d locked=%b expected 0/1", err_cnt0, locked0);
        end
    endtask

    task automatic test_hunt_discard();
        do_reset();
        drive(16'hAAAA, K_DATA);
        drive(W_COMMA, K_CTRL);
        drive(W_IDLE, K_CTRL);
        drive(W_IDLE, K_CTRL);
        vectors++;
        if (locked0 !== 1'b0 || rx_if0.rx_rdy !== 1'b0 || err_cnt0 !== 8'd0 || debug0[1:0] !== 2'd0) begin
            miscompares++;
            $display("FAIL hunt_discard: locked=%b rdy=%b err=%0d st=%0d expected 0/0/0/0",
                     locked0, rx_if0.rx_rdy, err_cnt0, debug0[1:0]);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        do_lock();
        for (int i = 0; i < 6; i++) begin
            drive(16'hA000 + 16'(i), K_DATA);
            if (i < 4) exp_q.push_back(16'hA000 + 16'(i));
        end
        drive(W_IDLE, K_CTRL);
        drive(W_IDLE, K_CTRL);
        vectors++;
        if (overflow0 !== 1'b1 || err_cnt0 !== 8'd0 || locked0 !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: ovf=%b err=%0d locked=%b expected 1/0/1", overflow0, err_cnt0, locked0);
        end
        err_clr = 1'b1;
        drive(W_IDLE, K_CTRL);
        err_clr = 1'b0;
        vectors++;
        if (overflow0 !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clr: ovf=%b expected=0", overflow0);
        end
        drain();
    endtask

    task automatic test_errors();
        do_reset();
        do_lock();
        for (int i = 0; i < 3; i++) begin
            drive(16'hB000 + 16'(i), K_DATA);
            exp_q.push_back(16'hB000 + 16'(i));
        end
        drive(W_COMMA, K_CTRL);
        drive(W_IDLE, K_CTRL);
        vectors++;
        if (locked0 !== 1'b0 || err_cnt0 !== 8'd1) begin
            miscompares++;
            $display("FAIL parity_comma: locked=%b err=%0d expected 0/1", locked0, err_cnt0);
        end
        drain();
        do_lock();
        drive(16'h3C1C, 2'b01);
        drive(W_IDLE, K_CTRL);
        vectors++;
        if (err_cnt0 !== 8'd2 || locked0 !== 1'b0) begin
            miscompares++;
            $display("FAIL mixed_k: err=%0d locked=%b expected 2/0", err_cnt0, locked0);
        end
        do_lock();
        drive(W_SYNC, K_CTRL);
        err_clr = 1'b1;
        drive(W_IDLE, K_CTRL);
        err_clr = 1'b0;
        vectors++;
        if (err_cnt0 !== 8'd1) begin
            miscompares++;
            $display("FAIL clr_with_err: err=%0d expected=1", err_cnt0);
        end
        for (int i = 0; i < 260; i++) begin
            burst();
            drive(16'h0000, 2'b10);
        end
        drive(W_IDLE, K_CTRL);
        vectors++;
        if (err_cnt0 !== 8'd255) begin
            miscompares++;
            $display("FAIL err_saturate: err=%0d expected=255", err_cnt0);
        end
        err_clr = 1'b1;
        drive(W_IDLE, K_CTRL);
        err_clr = 1'b0;
        vectors++;
        if (err_cnt0 !== 8'd0) begin
            miscompares++;
            $display("FAIL err_clear: err=%0d expected=0", err_cnt0);
        end
    endtask

    task automatic test_timeout();
        int n;
        logic [15:0] w;
        do_reset();
        do_lock();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            if (!locked1) break;
            n++;
            drive(W_IDLE, K_CTRL);
        end
        vectors++;
        if (n != 100 || err_cnt1 !== 8'd0) begin
            miscompares++;
            $display("FAIL timeout_drop: locked_cycles=%0d err=%0d expected 100/0", n, err_cnt1);
        end
        vectors++;
        if (locked0 !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_disabled: locked=%b expected=1", locked0);
        end

        do_reset();
        do_lock();
        n = 0;
        for (int i = 0; i < 300; i++) begin
            if (!locked1) break;
            n++;
            w = (i == 50 || i == 51) ? W_COMMA : (i == 52 || i == 53) ? W_SYNC : W_IDLE;
            drive(w, K_CTRL);
        end
        // Resync captured into the pipeline at edge 55 restarts the 100-cycle window.
        vectors++;
        if (n != 155 || err_cnt1 !== 8'd0) begin
            miscompares++;
            $display("FAIL timeout_resync: locked_cycles=%0d err=%0d expected 155/0", n, err_cnt1);
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        do_lock();
        drive(16'h0BAD, 2'b01);
        do_lock();
        drive(16'hC001, K_DATA);
        drive(16'hC002, K_DATA);
        drive(W_IDLE, K_CTRL);
        drive(W_IDLE, K_CTRL);
        vectors++;
        if (locked0 !== 1'b1 || rx_if0.rx_rdy !== 1'b1 || err_cnt0 !== 8'd1) begin
            miscompares++;
            $display("FAIL pre_reset: locked=%b rdy=%b err=%0d expected 1/1/1", locked0, rx_if0.rx_rdy, err_cnt0);
        end
        drive(W_COMMA, K_CTRL);
        drive(W_COMMA, K_CTRL);
        #2 dsp_rst_n = 1'b0;
        #1;
        vectors++;
        if (locked0 !== 1'b0 || rx_if0.rx_rdy !== 1'b0 || err_cnt0 !== 8'd0) begin
            miscompares++;
            $display("FAIL async_reset: locked=%b rdy=%b err=%0d expected 0/0/0", locked0, rx_if0.rx_rdy, err_cnt0);
        end
        @(posedge dsp_clk);
        #1 dsp_rst_n = 1'b1;
        drive(W_SYNC, K_CTRL);
        drive(W_SYNC, K_CTRL);
        drive(W_IDLE, K_CTRL);
        drive(W_IDLE, K_CTRL);
        vectors++;
        if (locked0 !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_relock: locked=%b expected=0", locked0);
        end
        do_lock();
        vectors++;
        if (locked0 !== 1'b1) begin
            miscompares++;
            $display("FAIL full_relock: locked=%b expected=1", locked0);
        end
    endtask

    initial begin
        test_reset();
        test_lock_data();
        test_hunt_discard();
        test_overflow();
        test_errors();
        test_timeout();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
